// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and request legality helper
// for the load/store unit.
package lsu_pkg;

    // funct3 width/sign codes (instr[14:12]); stores use only the first three
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // A funct3 is legal for a store only as SB/SH/SW; loads add LBU/LHU.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store unit.
// Computes byte enables, store-data replication, load lane extraction with
// sign/zero extension, and the misalignment flag.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses; otherwise the low address bits are ignored for those sizes.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    assign is_unsigned = funct3[2];
    assign byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel    = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Decode access size from funct3[1:0] into enables, replicated store data and extended load data
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

    // Misalignment: half needs addr[0]=0, word needs addr[1:0]=0
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-beat req/ack data-memory responder for
// LB/LH/LW/LBU/LHU/SB/SH/SW. FSM IDLE -> REQ -> DONE with a bus timeout.
// All outputs are registered. Optional feature macro: LSU_MISALIGN_TRAP_EN
// (handled in lsu_lane) turns misaligned half/word accesses into errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, nxt_state;
    logic [7:0]  cnt, nxt_cnt;

    // Request fields still needed after acceptance; the upper address bits,
    // enables and store data are held in the bus output registers.
    logic [1:0]  addr_lo_q, nxt_addr_lo_q;
    logic [2:0]  funct3_q, nxt_funct3_q;
    logic        we_q, nxt_we_q;

    logic        nxt_busy, nxt_done, nxt_err, nxt_mem_req, nxt_mem_we;
    logic [31:0] nxt_rdata, nxt_mem_wdata;
    logic [29:0] nxt_mem_addr;
    logic [3:0]  nxt_mem_be;

    logic        in_idle;
    logic [2:0]  lane_funct3;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_misaligned;

    // In IDLE the lane logic decodes the incoming request; in REQ it decodes
    // the latched one so the acked read word is extracted correctly.
    assign in_idle      = (state == ST_IDLE);
    assign lane_funct3  = in_idle ? funct3_i    : funct3_q;
    assign lane_addr_lo = in_idle ? addr_i[1:0] : addr_lo_q;

    lsu_lane u_lane (
        .funct3     (lane_funct3),
        .addr_lo    (lane_addr_lo),
        .wdata      (wdata_i),
        .rdata      (mem_rdata_i),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (lane_misaligned)
    );

    // Next-state and next-output logic for the IDLE/REQ/DONE transaction FSM
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_addr_lo_q = addr_lo_q;
        nxt_funct3_q  = funct3_q;
        nxt_we_q      = we_q;
        nxt_done      = 1'b0;
        nxt_err       = 1'b0;
        nxt_rdata     = rdata_o;
        nxt_mem_req   = mem_req_o;
        nxt_mem_we    = mem_we_o;
        nxt_mem_addr  = mem_addr_o;
        nxt_mem_be    = mem_be_o;
        nxt_mem_wdata = mem_wdata_o;

        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    nxt_addr_lo_q = addr_i[1:0];
                    nxt_funct3_q  = funct3_i;
                    nxt_we_q      = we_i;
                    if (!f3_legal(we_i, funct3_i) || lane_misaligned) begin
                        // Rejected without touching the bus
                        nxt_state = ST_DONE;
                        nxt_done  = 1'b1;
                        nxt_err   = 1'b1;
                        nxt_rdata = 32'd0;
                    end else begin
                        nxt_state     = ST_REQ;
                        nxt_cnt       = 8'd0;
                        nxt_mem_req   = 1'b1;
                        nxt_mem_we    = we_i;
                        nxt_mem_addr  = addr_i[31:2];
                        nxt_mem_be    = lane_be;
                        nxt_mem_wdata = lane_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    nxt_state   = ST_DONE;
                    nxt_mem_req = 1'b0;
                    nxt_done    = 1'b1;
                    if (!we_q) begin
                        nxt_rdata = lane_rdata;
                    end
                end else if (cnt == TO_LAST) begin
                    nxt_state   = ST_DONE;
                    nxt_mem_req = 1'b0;
                    nxt_done    = 1'b1;
                    nxt_err     = 1'b1;
                    nxt_rdata   = 32'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state   = ST_IDLE;
                nxt_mem_req = 1'b0;
            end
        endcase

        nxt_busy = (nxt_state != ST_IDLE);
    end

    // State, counter, latched request fields and all registered outputs
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
            we_q        <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 30'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            addr_lo_q   <= nxt_addr_lo_q;
            funct3_q    <= nxt_funct3_q;
            we_q        <= nxt_we_q;
            busy_o      <= nxt_busy;
            done_o      <= nxt_done;
            err_o       <= nxt_err;
            rdata_o     <= nxt_rdata;
            mem_req_o   <= nxt_mem_req;
            mem_we_o    <= nxt_mem_we;
            mem_addr_o  <= nxt_mem_addr;
            mem_be_o    <= nxt_mem_be;
            mem_wdata_o <= nxt_mem_wdata;
        end
    end

endmodule
